// File: rtl/dds_ctrl_pkg.sv
// dds_ctrl_pkg: shared sweep-controller types and default widths.
package dds_ctrl_pkg;
    localparam int PHASE_W = 31;
    localparam int DWELL_W = 24;
    typedef enum logic [1:0] {IDLE, LOAD, DWELL, DONE} state_e;
    typedef enum logic {DIR_UP, DIR_DOWN} dir_e;
endpackage

// File: rtl/dds_sweep_next.sv
// dds_sweep_next: next sweep increment, clamped so it never passes the stop value.
module dds_sweep_next #(
    parameter int PHASE_W = dds_ctrl_pkg::PHASE_W
) (
    input  logic [PHASE_W-1:0] cur_i,
    input  logic [PHASE_W-1:0] step_i,
    input  logic [PHASE_W-1:0] stop_i,
    input  dds_ctrl_pkg::dir_e dir_i,
    output logic [PHASE_W-1:0] next_o,
    output logic               at_stop_o
);
    import dds_ctrl_pkg::*;
    logic [PHASE_W:0] sum, diff;
    logic clamp;
    always_comb begin
        sum       = {1'b0, cur_i} + {1'b0, step_i};
        diff      = {1'b0, cur_i} - {1'b0, step_i};
        // the extra MSB is the carry (up) or borrow (down), both of which clamp
        clamp     = (step_i == '0) || ((dir_i == DIR_UP) ? (sum[PHASE_W] || sum[PHASE_W-1:0] >= stop_i)
                                                       : (diff[PHASE_W] || diff[PHASE_W-1:0] <= stop_i));
        next_o    = clamp ? stop_i : ((dir_i == DIR_UP) ? sum[PHASE_W-1:0] : diff[PHASE_W-1:0]);
        at_stop_o = (cur_i == stop_i);
    end
endmodule

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: steps the DDS increment from start to stop with a per-point dwell,
// single-shot or looping; all outputs registered.
module dds_sweep_ctrl #(
    parameter int PHASE_W = dds_ctrl_pkg::PHASE_W,
    parameter int DWELL_W = dds_ctrl_pkg::DWELL_W
) (
    input  logic               i_clk,
    input  logic               reset_n,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic               i_loop,
    input  logic [PHASE_W-1:0] i_f_start,
    input  logic [PHASE_W-1:0] i_f_stop,
    input  logic [PHASE_W-1:0] i_f_step,
    input  logic [DWELL_W-1:0] i_dwell,
    output logic [PHASE_W-1:0] o_increment,
    output logic               o_update,
    output logic               o_ce,
    output logic               o_busy,
    output logic               o_done
);
    import dds_ctrl_pkg::*;
    state_e             state_q;
    dir_e               dir_q;
    logic [PHASE_W-1:0] start_q, stop_q, step_q, next_inc, inc_d;
    logic [DWELL_W-1:0] dwell_q, cnt_q, dwell_d;
    logic               loop_q, at_stop;

    dds_sweep_next #(.PHASE_W(PHASE_W)) u_next (
        .cur_i    (o_increment),
        .step_i   (step_q),
        .stop_i   (stop_q),
        .dir_i    (dir_q),
        .next_o   (next_inc),
        .at_stop_o(at_stop)
    );

    // counter holds the cycles remaining after the current one, so dwell 0 and 1 coincide
    always_comb begin
        dwell_d = (i_dwell == '0) ? '0 : i_dwell - 1'b1;
        inc_d   = at_stop ? start_q : next_inc;
    end

    always_ff @(posedge i_clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            dir_q       <= DIR_UP;
            start_q     <= '0;
            stop_q      <= '0;
            step_q      <= '0;
            dwell_q     <= '0;
            cnt_q       <= '0;
            loop_q      <= 1'b0;
            o_increment <= '0;
            o_update    <= 1'b0;
            o_ce        <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            o_update <= 1'b0;
            o_done   <= 1'b0;
            case (state_q)
                IDLE: if (i_start && !i_abort) begin
                    start_q     <= i_f_start;
                    stop_q      <= i_f_stop;
                    step_q      <= i_f_step;
                    loop_q      <= i_loop;
                    dwell_q     <= dwell_d;
                    cnt_q       <= dwell_d;
                    dir_q       <= (i_f_stop >= i_f_start) ? DIR_UP : DIR_DOWN;
                    o_increment <= i_f_start;
                    o_update    <= 1'b1;
                    o_busy      <= 1'b1;
                    o_ce        <= 1'b1;
                    state_q     <= LOAD;
                end
                LOAD, DWELL: begin
                    if (i_abort) begin
                        o_busy  <= 1'b0;
                        state_q <= IDLE;
                    end else if (cnt_q != '0) begin
                        cnt_q   <= cnt_q - 1'b1;
                        state_q <= DWELL;
                    end else if (at_stop && !loop_q) begin
                        o_busy  <= 1'b0;
                        o_done  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        o_increment <= inc_d;
                        o_update    <= 1'b1;
                        cnt_q       <= dwell_q;
                        state_q     <= LOAD;
                    end
                end
                default: begin
                    o_busy  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule
